// File: rtl/dmem_port_arbiter.sv
// Single-port DMEM arbiter between the core and a remote (network) requester.
// Optional starvation guard enabled by defining DMEM_ARB_STARVATION_GUARD_EN.
module dmem_port_arbiter #(
    parameter int data_width_p   = 32,
    parameter int dmem_size_p    = 1024,
    parameter int starve_limit_p = 16,
    localparam int dmem_addr_width_lp = $clog2(dmem_size_p),
    localparam int mask_width_lp      = data_width_p / 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic                          core_v_i,
    input  logic                          core_w_i,
    input  logic [dmem_addr_width_lp-1:0] core_addr_i,
    input  logic [data_width_p-1:0]       core_data_i,
    input  logic [mask_width_lp-1:0]      core_mask_i,
    output logic                          core_yumi_o,
    output logic                          core_data_v_o,
    output logic [data_width_p-1:0]       core_data_o,

    input  logic                          remote_v_i,
    input  logic                          remote_w_i,
    input  logic [dmem_addr_width_lp-1:0] remote_addr_i,
    input  logic [data_width_p-1:0]       remote_data_i,
    input  logic [mask_width_lp-1:0]      remote_mask_i,
    output logic                          remote_yumi_o,
    output logic                          remote_data_v_o,
    output logic [data_width_p-1:0]       remote_data_o,

    output logic                          mem_v_o,
    output logic                          mem_w_o,
    output logic [dmem_addr_width_lp-1:0] mem_addr_o,
    output logic [data_width_p-1:0]       mem_data_o,
    output logic [mask_width_lp-1:0]      mem_mask_o,
    input  logic [data_width_p-1:0]       mem_data_i,

    output logic [7:0]                    starve_cnt_o
);

    // Handshake: a requester holds v_i (and its fields) until it sees yumi_o
    // high in the same cycle; yumi_o is a combinational accept and the request
    // is consumed on that rising edge. v_i may drop before yumi_o without effect.

    logic force_remote;
    logic pending_r;
    logic owner_r;      // 0 = core, 1 = remote

`ifdef DMEM_ARB_STARVATION_GUARD_EN
    localparam logic [7:0] starve_limit_lp = 8'(starve_limit_p);
    logic [7:0] starve_cnt_r;

    assign force_remote = remote_v_i & (starve_cnt_r == starve_limit_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_r <= '0;
        end else if (!remote_v_i || remote_yumi_o) begin
            starve_cnt_r <= '0;
        end else if (starve_cnt_r != starve_limit_lp) begin
            starve_cnt_r <= starve_cnt_r + 8'd1;
        end
    end

    assign starve_cnt_o = starve_cnt_r;
`else
    assign force_remote = 1'b0;
    assign starve_cnt_o = '0;
`endif

    assign core_yumi_o   = ~reset_i & core_v_i & ~force_remote;
    assign remote_yumi_o = ~reset_i & remote_v_i & (~core_v_i | force_remote);

    always_comb begin
        mem_v_o    = core_yumi_o | remote_yumi_o;
        mem_w_o    = core_w_i;
        mem_addr_o = core_addr_i;
        mem_data_o = core_data_i;
        mem_mask_o = core_mask_i;
        if (remote_yumi_o) begin
            mem_w_o    = remote_w_i;
            mem_addr_o = remote_addr_i;
            mem_data_o = remote_data_i;
            mem_mask_o = remote_mask_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_r <= 1'b0;
            owner_r   <= 1'b0;
        end else begin
            pending_r <= mem_v_o & ~mem_w_o;
            if (mem_v_o) begin
                owner_r <= remote_yumi_o;
            end
        end
    end

    // Gating with reset_i drops a response whose read was granted just before reset.
    assign core_data_v_o   = pending_r & ~owner_r & ~reset_i;
    assign remote_data_v_o = pending_r &  owner_r & ~reset_i;
    assign core_data_o     = mem_data_i;
    assign remote_data_o   = mem_data_i;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: behavioural DMEM, reference
// arbitration model, and a queue of expected read responses.
module tb_dmem_port_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int MW    = DW / 8;
    localparam int LIMIT = 4;
`ifdef DMEM_ARB_STARVATION_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          core_v_i, core_w_i, remote_v_i, remote_w_i;
    logic [AW-1:0] core_addr_i, remote_addr_i, mem_addr_o;
    logic [DW-1:0] core_data_i, remote_data_i, mem_data_o, mem_data_i;
    logic [MW-1:0] core_mask_i, remote_mask_i, mem_mask_o;
    logic          core_yumi_o, core_data_v_o, remote_yumi_o, remote_data_v_o;
    logic          mem_v_o, mem_w_o;
    logic [DW-1:0] core_data_o, remote_data_o;
    logic [7:0]    starve_cnt_o;

    dmem_port_arbiter #(
        .data_width_p(DW), .dmem_size_p(DEPTH), .starve_limit_p(LIMIT)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .core_v_i(core_v_i), .core_w_i(core_w_i), .core_addr_i(core_addr_i),
        .core_data_i(core_data_i), .core_mask_i(core_mask_i),
        .core_yumi_o(core_yumi_o), .core_data_v_o(core_data_v_o), .core_data_o(core_data_o),
        .remote_v_i(remote_v_i), .remote_w_i(remote_w_i), .remote_addr_i(remote_addr_i),
        .remote_data_i(remote_data_i), .remote_mask_i(remote_mask_i),
        .remote_yumi_o(remote_yumi_o), .remote_data_v_o(remote_data_v_o),
        .remote_data_o(remote_data_o),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i),
        .starve_cnt_o(starve_cnt_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    // behavioural single-port DMEM with 1-cycle read latency
    logic [DW-1:0] dmem [DEPTH];
    always @(posedge clk_i) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < MW; b++)
                    if (mem_mask_o[b]) dmem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
            end else begin
                mem_data_i <= dmem[mem_addr_o];
            end
        end
    end

    // scoreboard: {owner_is_remote, data}
    logic [DW:0]   exp_q [$];
    logic [DW-1:0] shadow [DEPTH];
    logic [7:0]    m_cnt;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // drive one cycle, check outputs at the falling edge, advance the model
    task automatic step(input logic rst,
                        input logic cv, input logic cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic [MW-1:0] cm,
                        input logic rv, input logic rw, input logic [AW-1:0] ra,
                        input logic [DW-1:0] rd, input logic [MW-1:0] rm);
        logic          fr, eg_c, eg_r, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [MW-1:0] em;
        logic [DW:0]   e;
        reset_i = rst;
        core_v_i = cv; core_w_i = cw; core_addr_i = ca; core_data_i = cd; core_mask_i = cm;
        remote_v_i = rv; remote_w_i = rw; remote_addr_i = ra; remote_data_i = rd; remote_mask_i = rm;
        @(negedge clk_i);
        fr   = GUARD_EN && rv && (m_cnt == 8'(LIMIT));
        eg_c = !rst && cv && !fr;
        eg_r = !rst && rv && (!cv || fr);
        chk("core_yumi", core_yumi_o, eg_c);
        chk("remote_yumi", remote_yumi_o, eg_r);
        chk("mem_v", mem_v_o, eg_c | eg_r);
        chk("starve_cnt", starve_cnt_o, m_cnt);
        if (exp_q.size() > 0 && !rst) begin
            e = exp_q.pop_front();
            chk("core_data_v", core_data_v_o, !e[DW]);
            chk("remote_data_v", remote_data_v_o, e[DW]);
            chk("rd_data", e[DW] ? remote_data_o : core_data_o, e[DW-1:0]);
        end else begin
            exp_q.delete();
            chk("core_data_v_idle", core_data_v_o, 1'b0);
            chk("remote_data_v_idle", remote_data_v_o, 1'b0);
        end
        if (eg_c || eg_r) begin
            ea = eg_r ? ra : ca;
            ew = eg_r ? rw : cw;
            ed = eg_r ? rd : cd;
            em = eg_r ? rm : cm;
            chk("mem_addr", mem_addr_o, ea);
            chk("mem_w", mem_w_o, ew);
            if (ew) begin
                chk("mem_data", mem_data_o, ed);
                chk("mem_mask", mem_mask_o, em);
                for (int b = 0; b < MW; b++)
                    if (em[b]) shadow[ea][8*b +: 8] = ed[8*b +: 8];
            end else begin
                exp_q.push_back({eg_r, shadow[ea]});
            end
        end
        if (rst || !GUARD_EN || !rv || eg_r) m_cnt = 8'd0;
        else if (m_cnt != 8'(LIMIT)) m_cnt = m_cnt + 8'd1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    endtask

    initial begin
        reset_i = 1'b1;
        core_v_i = 0; core_w_i = 0; core_addr_i = '0; core_data_i = '0; core_mask_i = '0;
        remote_v_i = 0; remote_w_i = 0; remote_addr_i = '0; remote_data_i = '0; remote_mask_i = '0;
        m_cnt = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            shadow[i] = $urandom;
            dmem[i]   = shadow[i];
        end
        shadow[6'h10] = 32'hCAFE_0001;
        dmem[6'h10]   = 32'hCAFE_0001;
        @(posedge clk_i);
        #1;

        // requests during reset are never granted
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 6'h10, '0, '0, 1, 0, 6'h11, '0, '0);

        // lone core read of 0x10
        step(0, 1, 0, 6'h10, '0, '0, 0, 0, '0, '0, '0);
        idle(1);

        // contention on reads for 40 cycles, then core drops
        for (int i = 0; i < 40; i++)
            step(0, 1, 0, AW'($urandom_range(0, DEPTH-1)), '0, '0,
                    1, 0, AW'($urandom_range(0, DEPTH-1)), '0, '0);
        step(0, 0, 0, '0, '0, '0, 1, 0, 6'h05, '0, '0);
        idle(1);

        // core write then remote read of the same word; then partial-mask write
        step(0, 1, 1, 6'h20, 32'h1234_5678, 4'hF, 0, 0, '0, '0, '0);
        step(0, 0, 0, '0, '0, '0, 1, 0, 6'h20, '0, '0);
        step(0, 1, 1, 6'h20, 32'hAABB_CCDD, 4'b0101, 0, 0, '0, '0, '0);
        step(0, 1, 0, 6'h20, '0, '0, 0, 0, '0, '0, '0);
        idle(1);

        // remote read immediately followed by reset drops its response
        step(0, 0, 0, '0, '0, '0, 1, 0, 6'h10, '0, '0);
        step(1, 1, 0, 6'h11, '0, '0, 1, 0, 6'h12, '0, '0);
        idle(2);

        // alternating lone core / remote reads, back to back
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) step(0, 1, 0, AW'(i), '0, '0, 0, 0, '0, '0, '0);
            else            step(0, 0, 0, '0, '0, '0, 1, 0, AW'(i), '0, '0);
        end
        idle(1);

        // random mix with withdrawals, writes, and occasional reset
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 AW'($urandom_range(0, 7)), $urandom, MW'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 AW'($urandom_range(0, 7)), $urandom, MW'($urandom));
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // absolute bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
